// File: rtl/ysyx_040978_div_ctrl_pkg.sv
// Shared definitions for the divide control path.
//   - op field bit positions ({word, rem, unsigned})
//   - 2-bit control FSM state encoding
//   - 32/64-bit most-negative constants used for signed overflow detection
//   - result_sel(): quotient/remainder select with word-op sign extension
package ysyx_040978_div_ctrl_pkg;

  localparam int unsigned OP_UNS  = 0;
  localparam int unsigned OP_REM  = 1;
  localparam int unsigned OP_WORD = 2;

  localparam logic [31:0] MOST_NEG_32 = 32'h8000_0000;
  localparam logic [63:0] MOST_NEG_64 = 64'h8000_0000_0000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10,
    S_KILL = 2'b11
  } div_state_t;

  // Word ops always sign-extend bit 31 of the selected result, unsigned ones too.
  function automatic logic [63:0] result_sel(input logic [2:0]  op,
                                             input logic [63:0] quot,
                                             input logic [63:0] rem);
    logic [63:0] res;
    res = op[OP_REM] ? rem : quot;
    if (op[OP_WORD]) begin
      res = {{32{res[31]}}, res[31:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/ysyx_040978_div_ctrl_prep.sv
// Combinational operand preparation and special-case detection.
//   op        : {word, rem, unsigned}
//   src1/src2 : raw dividend / divisor
//   dividend/divisor : operands as presented to the divider
//   div_signed: signed divide request
//   special   : divide-by-zero or signed overflow; no divider needed
//   quot/rem  : architectural quotient/remainder for the special cases
module ysyx_040978_div_prep
  import ysyx_040978_div_ctrl_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [63:0] src1,
  input  logic [63:0] src2,
  output logic [63:0] dividend,
  output logic [63:0] divisor,
  output logic        div_signed,
  output logic        special,
  output logic [63:0] quot,
  output logic [63:0] rem
);

  logic word;
  logic uns;
  logic div_zero;
  logic overflow;

  always_comb begin
    word = op[OP_WORD];
    uns  = op[OP_UNS];

    if (word) begin
      dividend = uns ? {32'b0, src1[31:0]} : {{32{src1[31]}}, src1[31:0]};
      divisor  = uns ? {32'b0, src2[31:0]} : {{32{src2[31]}}, src2[31:0]};
    end else begin
      dividend = src1;
      divisor  = src2;
    end
    div_signed = ~uns;

    div_zero = (divisor == '0);
    // Word operands are already sign-extended, so a full-width -1 divisor
    // and a low-half most-negative dividend identify the 32-bit overflow.
    overflow = ~uns && (divisor == '1) &&
               (word ? (dividend[31:0] == MOST_NEG_32) : (dividend == MOST_NEG_64));
    special  = div_zero | overflow;

    quot = div_zero ? '1 : dividend;
    rem  = div_zero ? dividend : '0;
  end

endmodule

// File: rtl/ysyx_040978_div_ctrl.sv
// Divide request controller sitting between the issue stage and an
// external iterative divider (instantiated by the parent).
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   : upstream request handshake; op/src1/src2 operands
//   flush               : kills any pending or completed operation
//   out_valid/out_ready : downstream result handshake; out_data result
//   div_*               : divider issue pulse, operands, done pulse, results
module ysyx_040978_div_ctrl
  import ysyx_040978_div_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  op,
  input  logic [63:0] src1,
  input  logic [63:0] src2,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        div_in_valid,
  output logic        div_signed,
  output logic [63:0] div_dividend,
  output logic [63:0] div_divisor,
  input  logic        div_out_valid,
  input  logic [63:0] div_quotient,
  input  logic [63:0] div_remainder
);

  div_state_t  state;
  div_state_t  state_nxt;

  logic [2:0]  op_q;
  logic        accept;
  logic        issue;
  logic        capture;

  logic [63:0] prep_dividend;
  logic [63:0] prep_divisor;
  logic        prep_signed;
  logic        special;
  logic [63:0] spec_quot;
  logic [63:0] spec_rem;

  ysyx_040978_div_prep u_prep (
    .op         (op),
    .src1       (src1),
    .src2       (src2),
    .dividend   (prep_dividend),
    .divisor    (prep_divisor),
    .div_signed (prep_signed),
    .special    (special),
    .quot       (spec_quot),
    .rem        (spec_rem)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Handshake outputs are pure state decodes, so out_ready never reaches
  // in_ready combinationally. Flush is tested first everywhere it matters.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    issue     = 1'b0;
    capture   = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid && !flush) begin
          accept = 1'b1;
          if (special) begin
            state_nxt = S_DONE;
          end else begin
            issue     = 1'b1;
            state_nxt = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (div_out_valid) begin
          if (flush) begin
            state_nxt = S_IDLE;
          end else begin
            capture   = 1'b1;
            state_nxt = S_DONE;
          end
        end else if (flush) begin
          // The divider cannot be aborted; drain its pending result.
          state_nxt = S_KILL;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (flush || out_ready) begin
          state_nxt = S_IDLE;
        end
      end
      S_KILL: begin
        if (div_out_valid) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      op_q         <= '0;
      div_in_valid <= 1'b0;
      div_signed   <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
      out_data     <= '0;
    end else begin
      div_in_valid <= issue;
      if (accept) begin
        op_q         <= op;
        div_signed   <= prep_signed;
        div_dividend <= prep_dividend;
        div_divisor  <= prep_divisor;
      end
      if (accept && special) begin
        out_data <= result_sel(op, spec_quot, spec_rem);
      end else if (capture) begin
        out_data <= result_sel(op_q, div_quotient, div_remainder);
      end
    end
  end

endmodule

// File: tb/tb_ysyx_040978_div_ctrl.sv
module tb_ysyx_040978_div_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = '0;
  logic [63:0] src1 = '0;
  logic [63:0] src2 = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic        div_in_valid;
  logic        div_signed;
  logic [63:0] div_dividend;
  logic [63:0] div_divisor;
  logic        div_out_valid = 1'b0;
  logic [63:0] div_quotient = '0;
  logic [63:0] div_remainder = '0;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  int div_lat = 5;
  bit spur = 1'b0;

  ysyx_040978_div_ctrl dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .op            (op),
    .src1          (src1),
    .src2          (src2),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .div_in_valid  (div_in_valid),
    .div_signed    (div_signed),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_out_valid (div_out_valid),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // RISC-V M-extension divide semantics straight from the ISA rules.
  function automatic logic [63:0] ref_div(input logic [2:0] o, input logic [63:0] a,
                                          input logic [63:0] b);
    logic [31:0] a32, b32, q32, r32;
    logic [63:0] q, r;
    int sa32, sb32;
    longint sa, sb;
    a32 = a[31:0];
    b32 = b[31:0];
    if (o[2]) begin
      sa32 = a32;
      sb32 = b32;
      if (b32 == 32'd0) begin q32 = 32'hFFFF_FFFF; r32 = a32; end
      else if (o[0]) begin q32 = a32 / b32; r32 = a32 % b32; end
      else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin q32 = a32; r32 = 32'd0; end
      else begin q32 = sa32 / sb32; r32 = sa32 % sb32; end
      return o[1] ? {{32{r32[31]}}, r32} : {{32{q32[31]}}, q32};
    end
    sa = a;
    sb = b;
    if (b == 64'd0) begin q = '1; r = a; end
    else if (o[0]) begin q = a / b; r = a % b; end
    else if (a == 64'h8000_0000_0000_0000 && b == '1) begin q = a; r = 64'd0; end
    else begin q = sa / sb; r = sa % sb; end
    return o[1] ? r : q;
  endfunction

  function automatic bit ref_special(input logic [2:0] o, input logic [63:0] a,
                                     input logic [63:0] b);
    if (o[2]) begin
      if (b[31:0] == 32'd0) return 1'b1;
      return !o[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF;
    end
    if (b == 64'd0) return 1'b1;
    return !o[0] && a == 64'h8000_0000_0000_0000 && b == '1;
  endfunction

  function automatic logic [63:0] ref_operand(input logic [2:0] o, input logic [63:0] s);
    if (!o[2]) return s;
    return o[0] ? {32'd0, s[31:0]} : {{32{s[31]}}, s[31:0]};
  endfunction

  // Divider stand-in: variable latency, one-cycle done pulse, optional stray pulse.
  int cnt = 0;
  logic [63:0] lat_q, lat_r;
  initial begin
    forever begin
      @(negedge clock);
      div_out_valid = 1'b0;
      if (reset) begin
        cnt = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            div_out_valid = 1'b1;
            div_quotient  = lat_q;
            div_remainder = lat_r;
          end
        end else if (spur) begin
          div_out_valid = 1'b1;
          div_quotient  = 64'hDEAD_BEEF_0BAD_F00D;
          div_remainder = 64'h1234_5678_9ABC_DEF0;
        end
        spur = 1'b0;
        if (div_in_valid) begin
          if (div_divisor == 64'd0) begin
            lat_q = '1;
            lat_r = div_dividend;
          end else if (div_signed) begin
            lat_q = $signed(div_dividend) / $signed(div_divisor);
            lat_r = $signed(div_dividend) % $signed(div_divisor);
          end else begin
            lat_q = div_dividend / div_divisor;
            lat_r = div_dividend % div_divisor;
          end
          cnt = div_lat;
        end
      end
    end
  end

  // Transaction-level model: an op is either in flight (result wanted),
  // being drained (result unwanted) or completed and waiting for pickup.
  bit          m_pending = 1'b0;
  bit          m_drain = 1'b0;
  bit          m_have = 1'b0;
  bit          m_issue = 1'b0;
  logic [63:0] m_res = '0;
  logic [63:0] m_pres = '0;
  logic [63:0] m_dvd = '0;
  logic [63:0] m_dvs = '0;
  bit          m_sgn = 1'b0;

  initial begin
    forever begin
      @(posedge clock);
      if (reset) begin
        m_pending = 1'b0; m_drain = 1'b0; m_have = 1'b0; m_issue = 1'b0;
        m_res = '0;
      end else begin
        m_issue = 1'b0;
        if (m_have) begin
          if (flush || out_ready) m_have = 1'b0;
        end else if (m_pending) begin
          if (div_out_valid) begin
            m_pending = 1'b0;
            if (!flush) begin m_have = 1'b1; m_res = m_pres; end
          end else if (flush) begin
            m_pending = 1'b0;
            m_drain = 1'b1;
          end
        end else if (m_drain) begin
          if (div_out_valid) m_drain = 1'b0;
        end else if (in_valid && !flush) begin
          if (ref_special(op, src1, src2)) begin
            m_have = 1'b1;
            m_res = ref_div(op, src1, src2);
          end else begin
            m_pending = 1'b1;
            m_issue = 1'b1;
            m_pres = ref_div(op, src1, src2);
            m_dvd = ref_operand(op, src1);
            m_dvs = ref_operand(op, src2);
            m_sgn = !op[0];
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (chk_en) begin
        check("in_ready", in_ready, !(m_pending || m_drain || m_have));
        check("out_valid", out_valid, m_have);
        check("div_in_valid", div_in_valid, m_issue);
        if (m_have) check("out_data", out_data, m_res);
        if (m_issue) begin
          check("div_dividend", div_dividend, m_dvd);
          check("div_divisor", div_divisor, m_dvs);
          check("div_signed", div_signed, m_sgn);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_op(input string name, input logic [2:0] o, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp, input bit special,
                       input bit chk_dvd, input logic [63:0] dvd);
    int n;
    in_valid = 1'b1; op = o; src1 = a; src2 = b;
    tick();
    in_valid = 1'b0;
    check({name, "_issue"}, div_in_valid, special ? 64'd0 : 64'd1);
    if (special) check({name, "_fast_valid"}, out_valid, 64'd1);
    if (chk_dvd) check({name, "_dividend"}, div_dividend, dvd);
    n = 0;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
    check({name, "_valid"}, out_valid, 64'd1);
    check({name, "_data"}, out_data, exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, "_idle"}, in_ready, 64'd1);
  endtask

  task automatic kill_wait(input string name);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (n < 200 && !seen) begin
      tick();
      n++;
      if (div_out_valid) begin
        seen = 1'b1;
        check({name, "_release"}, in_ready, 64'd1);
      end else begin
        check({name, "_no_valid"}, out_valid, 64'd0);
        check({name, "_held"}, in_ready, 64'd0);
      end
    end
    check({name, "_drained"}, seen, 64'd1);
    check({name, "_after_out_valid"}, out_valid, 64'd0);
  endtask

  initial begin
    logic [63:0] held;
    int n;

    repeat (3) tick();
    chk_en = 1'b1;
    check("rst_in_ready", in_ready, 64'd1);
    check("rst_out_valid", out_valid, 64'd0);
    check("rst_div_in_valid", div_in_valid, 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_dividend", div_dividend, 64'd0);
    check("rst_divisor", div_divisor, 64'd0);
    reset = 1'b0;
    tick();

    div_lat = 5;
    do_op("div_m7_2", 3'b000, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0, '0);
    do_op("rem_m7_2", 3'b010, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, '0);
    do_op("divu_by0", 3'b001, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, '0);
    do_op("remu_by0", 3'b011, 64'h1234, 64'd0, 64'h1234, 1'b1, 1'b0, '0);
    do_op("div_ovf", 3'b000, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000,
          1'b1, 1'b0, '0);
    do_op("divw_ovf", 3'b100, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000,
          1'b1, 1'b0, '0);
    do_op("remw_ovf", 3'b110, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 1'b1, 1'b0, '0);
    div_lat = 2;
    do_op("divuw", 3'b101, 64'hFFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1,
          64'h0000_0000_FFFF_FFFF);
    do_op("divw_neg", 3'b100, 64'h1234_5678_FFFF_FFF0, 64'h3, 64'hFFFF_FFFF_FFFF_FFFB,
          1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0);
    do_op("remuw", 3'b111, 64'hAAAA_0000_8000_0005, 64'h10, 64'd5, 1'b0, 1'b0, '0);

    // flush 10 cycles after issue
    div_lat = 30;
    in_valid = 1'b1; op = 3'b001; src1 = 64'd100; src2 = 64'd7;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("kill_entered", in_ready, 64'd0);
    kill_wait("kill10");
    div_lat = 3;
    do_op("divu_100_7", 3'b001, 64'd100, 64'd7, 64'd14, 1'b0, 1'b0, '0);

    // flush during the issue cycle
    div_lat = 6;
    in_valid = 1'b1; op = 3'b000; src1 = 64'd50; src2 = 64'd5;
    tick();
    in_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    kill_wait("kill_issue");

    // flush coinciding with the done pulse
    div_lat = 4;
    in_valid = 1'b1; op = 3'b000; src1 = 64'd50; src2 = 64'd5;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_done_idle", in_ready, 64'd1);
    check("flush_done_no_valid", out_valid, 64'd0);
    repeat (2) tick();

    // backpressure in DONE, plus a stray done pulse while holding
    div_lat = 2;
    in_valid = 1'b1; op = 3'b000; src1 = 64'd100; src2 = -64'sd3;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    held = out_data;
    check("bp_first_data", held, 64'hFFFF_FFFF_FFFF_FFDF);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) spur = 1'b1;
      tick();
      check("bp_valid", out_valid, 64'd1);
      check("bp_data", out_data, 64'hFFFF_FFFF_FFFF_FFDF);
      check("bp_in_ready", in_ready, 64'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_idle", in_ready, 64'd1);

    // stray done pulse in IDLE, flush in IDLE blocks accept
    spur = 1'b1;
    repeat (2) tick();
    in_valid = 1'b1; flush = 1'b1; op = 3'b001; src1 = 64'd9; src2 = 64'd3;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    check("flush_idle_ready", in_ready, 64'd1);
    check("flush_idle_no_issue", div_in_valid, 64'd0);

    // flush in DONE drops the result; flush beats out_ready
    in_valid = 1'b1; op = 3'b001; src1 = 64'd9; src2 = 64'd0;
    tick();
    in_valid = 1'b0;
    flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0; out_ready = 1'b0;
    check("flush_done_drop", out_valid, 64'd0);
    check("flush_done_ready", in_ready, 64'd1);

    // reset mid-operation
    div_lat = 20;
    in_valid = 1'b1; op = 3'b000; src1 = 64'd77; src2 = 64'd7;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("mid_rst_in_ready", in_ready, 64'd1);
    check("mid_rst_out_valid", out_valid, 64'd0);
    check("mid_rst_div_in_valid", div_in_valid, 64'd0);
    check("mid_rst_out_data", out_data, 64'd0);
    check("mid_rst_dividend", div_dividend, 64'd0);
    check("mid_rst_divisor", div_divisor, 64'd0);
    reset = 1'b0;
    tick();
    div_lat = 1;
    do_op("post_rst_rem", 3'b010, -64'sd20, 64'd6, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, '0);

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
